deinterleaver_accum: RTL and testbench

Scatter-accumulate counterpart of the rsweep_chng interleaver. It accepts z per-edge values per cycle in the same cycle order the interleaver uses to read left-side neurons. It regenerates the same left-neuron addresses and accumulates each value into a p-entry bank, one entry per left neuron. After a full junction (fo·p/z input beats), it streams the p sums out in neuron order. It sits on the backward/update path, where edge-wise contributions (for example weighted deltas) must be collapsed back onto left-side neurons.

---
 rtl/deinterleaver_accum.sv | 194 +++++++++++++++++++
 tb/tb_deinterleaver_accum.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deinterleaver_accum.sv
// deinterleaver_accum
// Scatter-accumulate counterpart of the rsweep_chng interleaver. Edge-wise
// values arrive z lanes per beat in interleaver read order; each lane is added
// into the left-neuron bank entry the interleaver would have addressed. After a
// full junction (fo*p/z beats) the p sums drain out in neuron order, z per beat,
// and each drained entry is cleared so the next junction starts from zero.

module deinterleaver_accum #(
    parameter int FO = 2,
    parameter int P  = 32,
    parameter int Z  = 8,
    parameter int W  = 16,
    localparam int NB = P / Z,
    localparam int SW = (NB > 1) ? $clog2(NB) : 1,
    // Element k (k = s*Z + j) sits at bits [SW*(k+1)-1 : SW*k]; element 0 is the LSB.
    parameter logic [FO*Z*SW-1:0] SWEEPSTART = {
        2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2,
        2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1
    },
    localparam int CW = $clog2(FO * NB),
    localparam int AW = W + $clog2(FO)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Z*W-1:0]  in_data,
    output logic [CW-1:0]   cycle_index,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Z*AW-1:0] out_data,
    output logic            done
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [CW-1:0] cycle_r;
    logic [SW-1:0] beat_r;
    logic          done_r;

    logic          accept_s;
    logic          take_s;
    logic          last_in_s;
    logic          last_out_s;
    logic [CW-1:0] sweep_s;
    logic [SW-1:0] row_s;

    logic [SW-1:0]         lane_row_s [Z];
    logic signed [AW-1:0]  lane_ext_s [Z];
    logic signed [AW-1:0]  bank_s     [P];

    // Starting row offset for sweep s, lane j.
    function automatic logic [SW-1:0] start_of(input logic [CW-1:0] s, input int j);
        return SWEEPSTART[(int'(s) * Z + j) * SW +: SW];
    endfunction

    assign accept_s   = (state_r == ST_ACCUM) && in_valid;
    assign take_s     = (state_r == ST_DRAIN) && out_ready;
    assign last_in_s  = (cycle_r == CW'(FO * NB - 1));
    assign last_out_s = (beat_r == SW'(NB - 1));
    assign sweep_s    = cycle_r >> SW;
    assign row_s      = cycle_r[SW-1:0];

    // Per-lane target row and sign-extended operand for the current beat.
    always_comb begin
        for (int j = 0; j < Z; j++) begin
            lane_row_s[j] = start_of(sweep_s, j) + row_s;
            lane_ext_s[j] = {{(AW-W){in_data[j*W+W-1]}}, in_data[j*W +: W]};
        end
    end

    // Bank: entry i is only ever reached by lane i%Z, so each entry compares
    // that lane's target row against its own row i/Z.
    for (genvar gi = 0; gi < P; gi++) begin : g_entry
        localparam int LANE = gi % Z;
        localparam int ROW  = gi / Z;
        logic signed [AW-1:0] entry_r;

        // Entry clears when its drain beat is taken, accumulates when targeted.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                entry_r <= '0;
            end else if (take_s && (beat_r == SW'(ROW))) begin
                entry_r <= '0;
            end else if (accept_s && (lane_row_s[LANE] == SW'(ROW))) begin
                entry_r <= entry_r + lane_ext_s[LANE];
            end else begin
                entry_r <= entry_r;
            end
        end

        assign bank_s[gi] = entry_r;
    end

    // Input beat counter, wraps after the last beat of a junction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_r <= '0;
        end else if (accept_s) begin
            cycle_r <= last_in_s ? '0 : cycle_r + CW'(1);
        end else begin
            cycle_r <= cycle_r;
        end
    end

    // Drain beat counter, wraps after the final drain handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_r <= '0;
        end else if (take_s) begin
            beat_r <= last_out_s ? '0 : beat_r + SW'(1);
        end else begin
            beat_r <= beat_r;
        end
    end

    // done pulses the cycle after the final drain handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= take_s && last_out_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ACCUM: begin
                if (accept_s && last_in_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (take_s && last_out_s) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_ACCUM;
        endcase
    end

    // Outputs decode registered state only; out_data is zero outside DRAIN.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        case (state_r)
            ST_ACCUM: begin
                in_ready = 1'b1;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    if (beat_r == SW'(b)) begin
                        for (int j = 0; j < Z; j++) begin
                            out_data[j*AW +: AW] = bank_s[b*Z + j];
                        end
                    end else begin
                        out_data = out_data;
                    end
                end
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign cycle_index = cycle_r;
    assign done        = done_r;

endmodule

// File: tb/tb_deinterleaver_accum.sv
// Directed bench for deinterleaver_accum with a small address-rule model used
// for the random-data junctions.

module tb_deinterleaver_accum;

    localparam int NBEAT = 8;   // fo*p/z
    localparam int NDRN  = 4;   // p/z
    localparam int AWT   = 17;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [2:0]   cycle_index;
    logic         out_valid;
    logic         out_ready;
    logic [135:0] out_data;
    logic         done;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     done_cnt = 0;
    int     cyc      = 0;
    int     done_cyc = 0;
    int     tb_cyc   = 0;
    int     ss [16]  = '{1,3,2,0,0,2,1,3,2,0,3,1,3,1,0,2};
    longint model   [32];
    longint exp_sum [32];

    always #5 clk = ~clk;

    deinterleaver_accum dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cycle_index(cycle_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .done       (done)
    );

    // Cycle counter and done-pulse bookkeeping.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 0;
        tb_cyc = 0;
    endtask

    task automatic set_exp_all(input longint v);
        for (int i = 0; i < 32; i++) exp_sum[i] = v;
    endtask

    task automatic exp_from_model();
        for (int i = 0; i < 32; i++) exp_sum[i] = model[i];
    endtask

    // Present one beat, wait for acceptance, and add it into the model.
    task automatic send_beat(input logic [127:0] d);
        int t = 0;
        int s, r, a;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        check($sformatf("cycle_index_b%0d", tb_cyc), cycle_index, tb_cyc);
        s = tb_cyc / 4;
        r = tb_cyc % 4;
        for (int j = 0; j < 8; j++) begin
            a = (((ss[s*8+j] + r) % 4) * 8) + j;
            model[a] += longint'($signed(d[j*16 +: 16]));
        end
        step();
        in_valid = 1'b0;
        tb_cyc   = (tb_cyc + 1) % NBEAT;
    endtask

    // Drain all sums against exp_sum; optionally stall 3 cycles before beat stall_at.
    task automatic drain(input int stall_at, input string tag);
        int t = 0;
        int d0;
        logic [135:0] held;
        while (!out_valid && t < 50) begin
            step();
            t++;
        end
        if (!out_valid) begin
            check({tag, "_out_valid_timeout"}, 0, 1);
            return;
        end
        check({tag, "_in_ready_low"}, in_ready, 0);
        d0 = done_cnt;
        for (int b = 0; b < NDRN; b++) begin
            if (b == stall_at) begin
                out_ready = 1'b0;
                held = out_data;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check({tag, "_stall_valid"}, out_valid, 1);
                    check({tag, "_stall_data"}, (out_data == held), 1);
                end
            end
            out_ready = 1'b1;
            for (int j = 0; j < 8; j++) begin
                check($sformatf("%s_n%0d", tag, b*8+j),
                      longint'($signed(out_data[j*AWT +: AWT])), exp_sum[b*8+j]);
            end
            step();
        end
        out_ready = 1'b0;
        check({tag, "_done_high"}, done, 1);
        check({tag, "_in_ready_back"}, in_ready, 1);
        check({tag, "_out_valid_low"}, out_valid, 0);
        step();
        check({tag, "_done_low"}, done, 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        logic [127:0] d;
        int prev_done;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clear_model();

        // Reset and idle
        step(); step(); step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_cycle_index", cycle_index, 0);
        check("rst_out_data_zero", (out_data == '0), 1);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_cycle_index", cycle_index, 0);
        check("idle_no_done", done_cnt, 0);

        // Address check: beat 0 lane 0 = 5 lands on neuron 8
        clear_model();
        set_exp_all(0);
        exp_sum[8] = 5;
        for (int b = 0; b < NBEAT; b++) send_beat((b == 0) ? 128'd5 : 128'd0);
        drain(-1, "addr0");

        // Beat 4 lane 0 = 5 lands on neuron 16
        clear_model();
        set_exp_all(0);
        exp_sum[16] = 5;
        for (int b = 0; b < NBEAT; b++) send_beat((b == 4) ? 128'd5 : 128'd0);
        drain(-1, "addr4");

        // Coverage: every neuron gets exactly two contributions
        clear_model();
        set_exp_all(2);
        for (int b = 0; b < NBEAT; b++) send_beat({8{16'h0001}});
        drain(-1, "ones");

        clear_model();
        set_exp_all(65534);
        for (int b = 0; b < NBEAT; b++) send_beat({8{16'h7FFF}});
        drain(-1, "maxpos");

        clear_model();
        set_exp_all(-65536);
        for (int b = 0; b < NBEAT; b++) send_beat({8{16'h8000}});
        drain(-1, "maxneg");

        // Backpressure: random input gaps and a mid-drain stall
        clear_model();
        for (int b = 0; b < NBEAT; b++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
            d = {$urandom, $urandom, $urandom, $urandom};
            send_beat(d);
        end
        exp_from_model();
        drain(2, "bp");

        // Reset mid-junction discards partial sums
        clear_model();
        for (int b = 0; b < 5; b++) send_beat({8{16'h0003}});
        reset_n = 1'b0;
        step(); step();
        check("midrst_cycle_index", cycle_index, 0);
        check("midrst_out_valid", out_valid, 0);
        reset_n = 1'b1;
        step();
        clear_model();
        set_exp_all(2);
        for (int b = 0; b < NBEAT; b++) send_beat({8{16'h0001}});
        drain(-1, "postrst");

        // Back-to-back junctions with no idle beyond the done cycle
        prev_done = 0;
        for (int jn = 0; jn < 3; jn++) begin
            clear_model();
            for (int b = 0; b < NBEAT; b++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                send_beat(d);
            end
            exp_from_model();
            drain(-1, $sformatf("b2b%0d", jn));
            if (jn > 0) check($sformatf("b2b%0d_period", jn), done_cyc - prev_done, 13);
            prev_done = done_cyc;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
